xor_fault_monitor: RTL and testbench
====================================

Name: xor_fault_monitor

Overview:
Stimulus and checker for the laser-attacked 6-input XOR target. It drives the target's 6-bit input bus and samples its parity output. It then compares the sampled output against the expected parity and counts mismatches (laser-induced faults). It sits beside the target in the same top level and runs either an exhaustive 64-pattern sweep or a continuous hold of one pattern while the laser scans.

Parameters:
SETTLE_CYCLES, 4, clocks between driving a pattern and sampling the synchronised output; legal range 2..255.
CNT_W, 16, width of the saturating fault counter.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a run; accepted only in IDLE.
abort  input  1  ends any run; sampled every cycle.
mode  input  1  0 = single sweep of patterns 0..63; 1 = continuous hold of pattern_in.
pattern_in  input  6  fixed pattern for mode 1; captured when start is accepted.
a_out  output  6  drive to target inputs.
q_in  input  1  target parity output; treated as asynchronous.
busy  output  1  high from start acceptance until return to IDLE.
done  output  1  one-cycle pulse at normal sweep completion.
fault_count  output  CNT_W  number of mismatched samples in the current or last run.
first_fault_valid  output  1  set at the first mismatch of a run.
first_fault_pattern  output  6  a_out value at the first mismatch.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, a_out=0, busy=0, done=0, fault_count=0, first_fault_valid=0, first_fault_pattern=0, synchroniser flops=0.
- q_in passes through a 2-flop synchroniser; q_s is the second flop.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0. Start acceptance requires start=1 and abort=0.
  - On acceptance: clear fault_count, first_fault_valid and first_fault_pattern.
  - Latch mode and pattern_in.
  - Set a_out to 0 in mode 0, or to pattern_in in mode 1.
  - Go to DRIVE.
- DRIVE: one cycle, with a_out stable; then go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
- SETTLE: decrement the counter; at 0 go to SAMPLE.
- SAMPLE: one cycle; expected = XOR reduction of a_out.
  - If q_s != expected:
    - fault_count increments, saturating at all-ones.
    - If first_fault_valid=0: set first_fault_valid and capture a_out.
  - Mode 0: if a_out=63, go to DONE; otherwise increment a_out and go to DRIVE.
  - Mode 1: a_out unchanged; go to DRIVE (loops until abort).
- DONE: done=1 for exactly one cycle, busy drops, then IDLE. a_out holds its last value until the next start.
- Per-pattern period = SETTLE_CYCLES+2 clocks.
- Mode 0 timing: for a start accepted at edge 0, done is high in cycle 64*(SETTLE_CYCLES+2)+1. This is 385 with defaults.
- abort=1 in any non-IDLE state: go to IDLE on the next edge, with busy=0 and no done pulse.
  - Counters and first-fault registers keep their values.
  - If abort coincides with SAMPLE, that sample is still evaluated.
- start while busy is ignored. pattern_in and mode changes mid-run are ignored.
- Reset mid-run overrides everything and returns all outputs to their reset values immediately.

Test Plan:
- Fault-free model (q_in = parity of a_out), mode 0, start -> done pulse 385 cycles after acceptance; fault_count=0; first_fault_valid=0; a_out=63 after done.
- q_in stuck at 0, mode 0 -> fault_count=32; first_fault_pattern=6'h01; first_fault_valid=1.
- q_in inverted parity, mode 0 -> fault_count=64; first_fault_pattern=6'h00. Repeat with CNT_W=4 -> fault_count saturates at 15.
- Mode 1, pattern_in=6'h3F, model correct except inverted during exactly 3 SAMPLE windows -> fault_count=3 and first_fault_pattern=6'h3F; then abort -> busy=0 next cycle, no done pulse, count stays 3.
- start pulsed again mid-sweep -> ignored, sweep completes at the original time. Second start after done -> counters clear on acceptance.
- rst_n low at pattern 20 of a sweep -> all outputs 0 immediately (asynchronously). After release, a new start runs a full 64-pattern sweep.

Source files
------------

// File: rtl/xor_fault_monitor.sv
// Stimulus/checker for a 6-input XOR target: drives patterns, samples the
// synchronised parity output and counts mismatches as injected faults.
module xor_fault_monitor #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [5:0]       pattern_in,
  output logic [5:0]       a_out,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] fault_count,
  output logic             first_fault_valid,
  output logic [5:0]       first_fault_pattern
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [5:0] LAST_PATTERN = 6'h3F;

  state_t     state_q, state_d;
  logic       q_meta, q_s;
  logic       mode_q;
  logic [7:0] settle_cnt;
  logic       start_ok;
  logic       mismatch;

  assign start_ok = (state_q == ST_IDLE) && start && !abort;
  assign mismatch = q_s != (^a_out);
  assign busy     = state_q != ST_IDLE;
  assign done     = state_q == ST_DONE;

  // The target output changes asynchronously to clk when the laser hits it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta <= 1'b0;
      q_s    <= 1'b0;
    end else begin
      q_meta <= q_in;
      q_s    <= q_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == 8'd0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (!mode_q && a_out == LAST_PATTERN) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out               <= '0;
      mode_q              <= 1'b0;
      settle_cnt          <= '0;
      fault_count         <= '0;
      first_fault_valid   <= 1'b0;
      first_fault_pattern <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            mode_q              <= mode;
            a_out               <= mode ? pattern_in : 6'd0;
            fault_count         <= '0;
            first_fault_valid   <= 1'b0;
            first_fault_pattern <= '0;
          end
        end
        ST_DRIVE:  settle_cnt <= SETTLE_LOAD;
        ST_SETTLE: if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        ST_SAMPLE: begin
          // A sample coinciding with abort is still scored.
          if (mismatch) begin
            if (fault_count != '1) fault_count <= fault_count + CNT_W'(1);
            if (!first_fault_valid) begin
              first_fault_valid   <= 1'b1;
              first_fault_pattern <= a_out;
            end
          end
          if (!mode_q && a_out != LAST_PATTERN && !abort) a_out <= a_out + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_fault_monitor.sv
// Directed bench for xor_fault_monitor: fault-free, stuck, inverted, held
// pattern with transient faults, abort, ignored start and mid-run reset.
module tb_xor_fault_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_sat, abort, mode;
  logic [5:0]  pattern_in;
  logic [5:0]  a_out, a_out_sat;
  logic        q_in, q_in_sat;
  logic        busy, done, busy_sat, done_sat;
  logic [15:0] fault_count;
  logic [3:0]  fault_count_sat;
  logic        ffv, ffv_sat;
  logic [5:0]  ffp, ffp_sat;

  // 0 = correct parity, 1 = stuck at 0, 2 = inverted parity
  logic [1:0]  qsel;
  logic        inj;

  int checks   = 0;
  int failures = 0;
  int done_at, pulses;

  always #5 clk = ~clk;

  assign q_in     = (qsel == 2'd1) ? 1'b0 : ((^a_out) ^ (qsel == 2'd2) ^ inj);
  assign q_in_sat = ~(^a_out_sat);

  xor_fault_monitor #(.SETTLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .pattern_in(pattern_in), .a_out(a_out), .q_in(q_in), .busy(busy),
    .done(done), .fault_count(fault_count), .first_fault_valid(ffv),
    .first_fault_pattern(ffp)
  );

  xor_fault_monitor #(.SETTLE_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat), .abort(abort), .mode(1'b0),
    .pattern_in(6'd0), .a_out(a_out_sat), .q_in(q_in_sat), .busy(busy_sat),
    .done(done_sat), .fault_count(fault_count_sat), .first_fault_valid(ffv_sat),
    .first_fault_pattern(ffp_sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic m, input logic [5:0] p);
    mode       = m;
    pattern_in = p;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Runs up to 400 edges after acceptance; optionally re-pulses start and
  // changes mode/pattern mid-run, which the DUT must ignore.
  task automatic sweep(input bit poke, output int at, output int n);
    at = -1;
    n  = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (poke && i == 100) begin start = 1'b1; mode = 1'b1; pattern_in = 6'h15; end
      if (poke && i == 101) begin start = 1'b0; mode = 1'b0; end
      if (done) begin
        if (at < 0) at = i;
        n++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_sat = 1'b0; abort = 1'b0;
    mode = 1'b0; pattern_in = 6'd0; qsel = 2'd0; inj = 1'b0;
    #2;
    check("rst_a_out", a_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault_count", fault_count, 0);
    check("rst_ffv", ffv, 0);
    check("rst_ffp", ffp, 0);
    #10 rst_n = 1'b1;
    tick();

    // Fault-free sweep with an ignored mid-run start and mode/pattern change
    qsel = 2'd0;
    start_run(1'b0, 6'h2A);
    check("ok_busy_after_start", busy, 1);
    check("ok_a_out_first", a_out, 0);
    sweep(1'b1, done_at, pulses);
    check("ok_done_edge", done_at, 384);
    check("ok_done_pulses", pulses, 1);
    check("ok_fault_count", fault_count, 0);
    check("ok_ffv", ffv, 0);
    check("ok_a_out_last", a_out, 63);
    check("ok_busy_end", busy, 0);

    // Inverted parity on both instances; narrow counter saturates
    qsel = 2'd2;
    start_sat = 1'b1;
    start_run(1'b0, 6'h00);
    start_sat = 1'b0;
    sweep(1'b0, done_at, pulses);
    check("inv_done_edge", done_at, 384);
    check("inv_fault_count", fault_count, 64);
    check("inv_ffv", ffv, 1);
    check("inv_ffp", ffp, 0);
    check("sat_fault_count", fault_count_sat, 15);
    check("sat_ffv", ffv_sat, 1);
    check("sat_ffp", ffp_sat, 0);
    check("sat_busy_end", busy_sat, 0);
    check("sat_done_end", done_sat, 0);

    // Stuck-at-0: second start clears counters on acceptance
    qsel = 2'd1;
    start_run(1'b0, 6'h00);
    check("stk_cleared_count", fault_count, 0);
    check("stk_cleared_ffv", ffv, 0);
    sweep(1'b0, done_at, pulses);
    check("stk_done_edge", done_at, 384);
    check("stk_fault_count", fault_count, 32);
    check("stk_ffv", ffv, 1);
    check("stk_ffp", ffp, 1);

    // Hold 6'h3F; invert q_in so exactly samples at edges 12, 18, 24 fail
    qsel = 2'd0;
    start_run(1'b1, 6'h3F);
    repeat (9) tick();
    inj = 1'b1;
    repeat (13) tick();
    inj = 1'b0;
    pattern_in = 6'h00;
    mode       = 1'b0;
    repeat (18) tick();
    check("hold_fault_count", fault_count, 3);
    check("hold_ffv", ffv, 1);
    check("hold_ffp", ffp, 6'h3F);
    check("hold_a_out", a_out, 6'h3F);
    check("hold_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_fault_count", fault_count, 3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_ffp_kept", ffp, 6'h3F);

    // Asynchronous reset while pattern 20 is driven
    qsel = 2'd2;
    start_run(1'b0, 6'h00);
    repeat (121) tick();
    check("mid_a_out", a_out, 20);
    check("mid_fault_count", fault_count, 20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a_out", a_out, 0);
    check("arst_busy", busy, 0);
    check("arst_fault_count", fault_count, 0);
    check("arst_ffv", ffv, 0);
    check("arst_ffp", ffp, 0);
    check("arst_done", done, 0);
    #4 rst_n = 1'b1;
    tick();
    qsel = 2'd0;
    start_run(1'b0, 6'h00);
    sweep(1'b0, done_at, pulses);
    check("post_rst_done_edge", done_at, 384);
    check("post_rst_pulses", pulses, 1);
    check("post_rst_fault_count", fault_count, 0);
    check("post_rst_a_out", a_out, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
